average_collector: RTL and testbench
====================================

Name: average_collector

Overview:
- Receiver for the vertical-average stream of a 16x8 byte frame. The averager emits 15 rows x 8 columns = 120 averaged bytes, one per `valid` cycle.
- Captures the stream row-major into a 15x8 buffer, tracks frame progress, and keeps a running checksum.
- Offers a random-access read port so downstream logic or the bench can fetch any averaged pixel.
- Sits directly after the averager output (`valid`/`out`) in the image path.

Parameters:
- ROWS, 15, number of averaged rows per frame
- COLS, 8, number of columns per row (power of two)
- WIDTH, 8, pixel width in bits

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- valid  input  1  averaged byte present on `in_data` this cycle
- in_data  input  WIDTH  averaged pixel from the averager
- clear  input  1  synchronous frame restart
- rd_en  input  1  read request
- rd_row  input  4  read row index
- rd_col  input  3  read column index
- rd_data  output  WIDTH  read result
- rd_valid  output  1  `rd_data` valid, one-cycle pulse
- row_done  output  1  one-cycle pulse when the last column of a row is written
- frame_done  output  1  level; frame of ROWS*COLS bytes captured
- checksum  output  16  sum of all bytes captured this frame
- overflow  output  1  sticky; `valid` seen while `frame_done` is high

Behaviour:
- Reset (`reset`=0, async): the following are all 0:
  - write pointer (row, col)
  - `frame_done`, `row_done`, `overflow`, `checksum`, `rd_data`, `rd_valid`
- Buffer contents are not reset.
- States:
  - COLLECT (after reset): accepts data.
  - DONE: frame complete; `frame_done`=1.
- COLLECT, `valid`=1:
  - Write `in_data` to buf[row][col].
  - `checksum` += `in_data`, zero-extended to 16 bits. Maximum 120*255 = 30600, so no wrap.
  - `col` increments.
  - When `col`==COLS-1: `col`→0, `row`++, `row_done` pulses the next cycle.
  - When `row`==ROWS-1 and `col`==COLS-1: go to DONE. `frame_done` rises the cycle after the 120th byte.
- COLLECT, `valid`=0: hold.
- DONE, `valid`=1: byte dropped; `buf`, `checksum` and pointer unchanged; `overflow`←1, sticky.
- `clear`=1, any state:
  - Pointer→0, `checksum`→0, `frame_done`→0, `overflow`→0, state→COLLECT.
  - Buffer contents kept.
  - `clear` beats `valid` in the same cycle; that byte is discarded.
- Read port:
  - `rd_en`=1 samples `rd_row`/`rd_col`.
  - Next cycle: `rd_valid`=1 and `rd_data`=buf[rd_row][rd_col]. Latency 1; back-to-back reads give one result per cycle.
  - `rd_row` ≥ ROWS: `rd_data`=0 and `rd_valid`=1.
  - `rd_en`=0: `rd_valid`=0, `rd_data` holds its last value.
- Read and write to the same location in the same cycle: read returns the old contents (read-before-write).
- Reads are legal in both states and during `clear`.
- `reset` asserted mid-frame: pointer, flags and checksum clear immediately; the next `valid` after release writes buf[0][0].
- `row_done` never pulses for bytes dropped in DONE.

Test Plan:
- Reset, then stream 120 bytes with value = index (0..119) on consecutive cycles:
  - `row_done` pulses 15 times, every 8 bytes.
  - `frame_done`=1 the cycle after the last byte.
  - `checksum`=7140.
- After a full frame, read (row 3, col 5) → one cycle later `rd_data`=29, `rd_valid`=1. Read row 15 → `rd_data`=0, `rd_valid`=1.
- Frame of all 255 with `valid` toggling every other cycle → `checksum`=30600, `frame_done` after byte 120, `overflow`=0.
- In DONE, drive `valid`=1 with `in_data`=0xAA → `overflow`=1 and stays; `checksum` unchanged; buf[0][0] unchanged. Then `clear` → `overflow`=0, `frame_done`=0.
- After 50 bytes, pulse `clear` together with `valid`=1 and `in_data`=0x11 → pointer 0, `checksum` 0, 0x11 not written. Next byte 0x22 lands at (0,0).
- Assert `reset` low asynchronously mid-frame (byte 70) → all outputs 0 without waiting for a clock edge. After release, a new 120-byte frame completes normally.

Source files
------------

// File: rtl/average_collector.sv
// Captures the 15x8 vertical-average stream into a buffer with a running checksum.
// Random-access read port with one-cycle latency and read-before-write semantics.
module average_collector #(
    parameter int ROWS  = 15,
    parameter int COLS  = 8,
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(COLS),
    localparam int AW   = 4 + CW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    input  logic             rd_en,
    input  logic [3:0]       rd_row,
    input  logic [CW-1:0]    rd_col,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             row_done,
    output logic             frame_done,
    output logic [15:0]      checksum,
    output logic             overflow
);

    typedef enum logic {COLLECT, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic [15:0]      sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic             rdone_q, rdone_d;
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;
    logic             we;

    logic [WIDTH-1:0] mem [ROWS*COLS];

    // COLS is a power of two, so {row, col} is the row-major address
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    assign wr_addr = {row_q, col_q};
    assign rd_addr = {rd_row, rd_col};

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        rdone_d = 1'b0;
        we      = 1'b0;
        if (clear) begin
            state_d = COLLECT;
            row_d   = '0;
            col_d   = '0;
            sum_d   = '0;
            ovf_d   = 1'b0;
        end else if (valid) begin
            unique case (state_q)
                COLLECT: begin
                    we    = 1'b1;
                    sum_d = sum_q + 16'(in_data);
                    if (col_q == CW'(COLS - 1)) begin
                        col_d   = '0;
                        row_d   = row_q + 4'd1;
                        rdone_d = 1'b1;
                        if (row_q == 4'(ROWS - 1)) begin
                            state_d = DONE;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                DONE: begin
                    ovf_d = 1'b1;
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= COLLECT;
            row_q    <= '0;
            col_q    <= '0;
            sum_q    <= '0;
            ovf_q    <= 1'b0;
            rdone_q  <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            sum_q    <= sum_d;
            ovf_q    <= ovf_d;
            rdone_q  <= rdone_d;
            rvalid_q <= rd_en;
            if (rd_en) begin
                rdata_q <= (rd_row < 4'(ROWS)) ? mem[rd_addr] : '0;
            end
        end
    end

    // Buffer has no reset; contents survive reset and clear
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= in_data;
        end
    end

    assign rd_data    = rdata_q;
    assign rd_valid   = rvalid_q;
    assign row_done   = rdone_q;
    assign frame_done = (state_q == DONE);
    assign checksum   = sum_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_average_collector.sv
// Bench for average_collector: read results go through a scoreboard queue
// checked by a monitor; flags and checksum are checked directly.
module tb_average_collector;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       clear = 1'b0;
    logic       rd_en = 1'b0;
    logic [3:0] rd_row = '0;
    logic [2:0] rd_col = '0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       row_done;
    logic       frame_done;
    logic [15:0] checksum;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int rdone_cnt = 0;
    logic [7:0] rd_exp[$];

    average_collector dut (
        .clk(clk), .reset(reset), .valid(valid), .in_data(in_data),
        .clear(clear), .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .rd_valid(rd_valid), .row_done(row_done),
        .frame_done(frame_done), .checksum(checksum), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops an expected read result whenever rd_valid is seen
    always @(negedge clk) begin
        if (reset && row_done) rdone_cnt++;
        if (reset && rd_valid) begin
            checks++;
            if (rd_exp.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got rd_valid with data %0d, expected no read", rd_data);
            end else begin
                logic [7:0] e;
                e = rd_exp.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %0d expected %0d", rd_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int r, input int c, input logic [7:0] e);
        rd_en  = 1'b1;
        rd_row = 4'(r);
        rd_col = 3'(c);
        rd_exp.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        tick();
        tick();
        while (rd_exp.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("rd_queue_empty", rd_exp.size(), 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_frame_done", frame_done, 0);
        check("rst_row_done", row_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_checksum", checksum, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        tick();
        reset = 1'b1;
        tick();

        // Frame 1: value = index, consecutive cycles
        rdone_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            valid = 1'b1;
            in_data = 8'(i);
            if (i == 119) check("f1_frame_done_pre", frame_done, 0);
            tick();
        end
        valid = 1'b0;
        check("f1_frame_done", frame_done, 1);
        check("f1_checksum", checksum, 7140);
        check("f1_overflow", overflow, 0);
        tick();
        check("f1_row_done_cnt", rdone_cnt, 15);

        rd(3, 5, 8'd29);
        rd(15, 0, 8'd0);
        rd(0, 0, 8'd0);
        rd(14, 7, 8'd119);
        drain();
        check("rd_valid_idle", rd_valid, 0);
        check("rd_data_hold", rd_data, 119);

        // Frame 2: all 255, valid every other cycle
        do_clear();
        check("clr_frame_done", frame_done, 0);
        check("clr_checksum", checksum, 0);
        for (int i = 0; i < 240; i++) begin
            valid = (i % 2 == 0);
            in_data = 8'hFF;
            if (i == 238) check("f2_frame_done_pre", frame_done, 0);
            tick();
        end
        valid = 1'b0;
        check("f2_frame_done", frame_done, 1);
        check("f2_checksum", checksum, 30600);
        check("f2_overflow", overflow, 0);
        rd(7, 3, 8'hFF);
        drain();

        // Overflow in DONE
        valid = 1'b1;
        in_data = 8'hAA;
        tick();
        valid = 1'b0;
        check("ovf_set", overflow, 1);
        check("ovf_checksum", checksum, 30600);
        tick();
        tick();
        check("ovf_sticky", overflow, 1);
        check("ovf_frame_done", frame_done, 1);
        rd(0, 0, 8'hFF);
        drain();
        do_clear();
        check("ovf_clr_overflow", overflow, 0);
        check("ovf_clr_frame_done", frame_done, 0);

        // Clear mid-frame beats valid
        for (int i = 0; i < 50; i++) begin
            valid = 1'b1;
            in_data = 8'(i + 1);
            tick();
        end
        check("mid_checksum", checksum, 1275);
        clear = 1'b1;
        valid = 1'b1;
        in_data = 8'h11;
        tick();
        clear = 1'b0;
        valid = 1'b0;
        check("mid_clr_checksum", checksum, 0);
        valid = 1'b1;
        in_data = 8'h22;
        tick();
        valid = 1'b0;
        check("mid_22_checksum", checksum, 34);
        rd(0, 0, 8'h22);
        rd(0, 1, 8'd2);
        drain();

        // Async reset mid-frame
        do_clear();
        for (int i = 0; i < 70; i++) begin
            valid = 1'b1;
            in_data = 8'(200 - i);
            tick();
        end
        valid = 1'b0;
        check("pre_rst_checksum", checksum, 11585);
        rd(0, 0, 8'd200);
        drain();
        check("pre_rst_rd_data", rd_data, 200);
        #2;
        reset = 1'b0;
        #1;
        check("arst_checksum", checksum, 0);
        check("arst_rd_data", rd_data, 0);
        check("arst_frame_done", frame_done, 0);
        check("arst_overflow", overflow, 0);
        check("arst_rd_valid", rd_valid, 0);
        check("arst_row_done", row_done, 0);
        tick();
        reset = 1'b1;
        tick();

        rdone_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            valid = 1'b1;
            in_data = 8'((i % 8) + 1);
            tick();
        end
        valid = 1'b0;
        check("f3_frame_done", frame_done, 1);
        check("f3_checksum", checksum, 540);
        tick();
        check("f3_row_done_cnt", rdone_cnt, 15);
        rd(0, 0, 8'd1);
        rd(14, 7, 8'd8);
        rd(9, 2, 8'd3);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
